// File: rtl/biriscv_pipe_pkg.sv
// Shared types and constants for the deep execute pipeline controller:
// exception codes, control-bit indices and the per-stage record.
package biriscv_pipe_pkg;

    localparam int EXCEPTION_W = 6;

    localparam logic [EXCEPTION_W-1:0] EXC_NONE             = 6'd0;
    localparam logic [EXCEPTION_W-1:0] EXC_ILLEGAL_INSTR    = 6'd2;
    localparam logic [EXCEPTION_W-1:0] EXC_BREAKPOINT       = 6'd3;
    localparam logic [EXCEPTION_W-1:0] EXC_MISALIGNED_LOAD  = 6'd4;
    localparam logic [EXCEPTION_W-1:0] EXC_FAULT_LOAD       = 6'd5;
    localparam logic [EXCEPTION_W-1:0] EXC_MISALIGNED_STORE = 6'd6;
    localparam logic [EXCEPTION_W-1:0] EXC_FAULT_STORE      = 6'd7;
    localparam logic [EXCEPTION_W-1:0] EXC_PAGE_FAULT_LOAD  = 6'd13;
    localparam logic [EXCEPTION_W-1:0] EXC_PAGE_FAULT_STORE = 6'd15;

    localparam int CTRL_LOAD     = 0;
    localparam int CTRL_STORE    = 1;
    localparam int CTRL_MUL      = 2;
    localparam int CTRL_RD_VALID = 3;
    localparam int CTRL_W        = 4;

    typedef struct packed {
        logic                   valid;
        logic [CTRL_W-1:0]      ctrl;
        logic [31:0]            pc;
        logic [31:0]            opcode;
        logic [31:0]            result;
        logic [EXCEPTION_W-1:0] exception;
    } stage_t;

    function automatic logic is_mem_exception(input logic [EXCEPTION_W-1:0] code);
        case (code)
            EXC_MISALIGNED_LOAD, EXC_FAULT_LOAD, EXC_MISALIGNED_STORE,
            EXC_FAULT_STORE, EXC_PAGE_FAULT_LOAD, EXC_PAGE_FAULT_STORE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/biriscv_pipe_stage.sv
// One execute-stage register slice: hold, clear, load with optional
// result/exception override applied to the incoming record.
module biriscv_pipe_stage
    import biriscv_pipe_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   hold_i,
    input  logic                   clear_i,
    input  stage_t                 stage_i,
    input  logic                   ovr_result_i,
    input  logic [31:0]            ovr_result_val_i,
    input  logic                   ovr_exc_i,
    input  logic [EXCEPTION_W-1:0] ovr_exc_val_i,
    output stage_t                 stage_o
);

    stage_t stage_q;
    stage_t stage_d;

    always_comb begin
        stage_d = stage_q;
        if (!hold_i) begin
            if (clear_i || !stage_i.valid) begin
                stage_d = '0;
            end else begin
                stage_d = stage_i;
                if (ovr_result_i) stage_d.result    = ovr_result_val_i;
                if (ovr_exc_i)    stage_d.exception = ovr_exc_val_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) stage_q <= '0;
        else       stage_q <= stage_d;
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/biriscv_pipe_ctrl_deep.sv
// NUM_STAGES-deep execute pipeline controller with forwarding, memory stall
// and oldest-first squash. Optional perf counters: BIRISCV_PIPE_PERF_EN.
module biriscv_pipe_ctrl_deep
    import biriscv_pipe_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned LOAD_STAGE = 2,
    parameter int unsigned MUL_STAGE  = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    issue_valid_i,
    input  logic                    issue_accept_i,
    input  logic                    issue_stall_i,
    input  logic                    issue_lsu_i,
    input  logic                    issue_mul_i,
    input  logic                    issue_rd_valid_i,
    input  logic [5:0]              issue_exception_i,
    input  logic [31:0]             issue_pc_i,
    input  logic [31:0]             issue_opcode_i,
    input  logic [31:0]             alu_result_e1_i,
    input  logic                    mem_complete_i,
    input  logic [31:0]             mem_result_i,
    input  logic [5:0]              mem_exception_i,
    input  logic [31:0]             mul_result_i,
    input  logic                    squash_i,
    output logic [NUM_STAGES-1:0]   stage_valid_o,
    output logic [5*NUM_STAGES-1:0] stage_rd_o,
    output logic [32*NUM_STAGES-1:0] stage_result_o,
    output logic                    stall_o,
    output logic                    squash_o,
    output logic                    valid_wb_o,
    output logic [4:0]              rd_wb_o,
    output logic [31:0]             result_wb_o,
    output logic [31:0]             pc_wb_o,
    output logic [5:0]              exception_wb_o
`ifdef BIRISCV_PIPE_PERF_EN
    ,
    output logic [31:0]             perf_retired_o,
    output logic [31:0]             perf_stall_cycles_o
`endif
);

    localparam int unsigned LOAD_IDX = LOAD_STAGE - 1;
    localparam int unsigned MUL_IDX  = MUL_STAGE - 1;
    localparam int unsigned LAST_IDX = NUM_STAGES - 1;

    stage_t                 stage_q  [NUM_STAGES];
    stage_t                 stage_in [NUM_STAGES];
    logic [NUM_STAGES-1:0]  stage_clr;
    logic [NUM_STAGES-1:0]  is_ls, is_mul, fwd_ready;
    logic [NUM_STAGES-1:0]  ovr_res_en, ovr_exc_en, in_ovr_res_en, in_ovr_exc_en;
    logic [31:0]            ovr_res_val [NUM_STAGES];
    logic [31:0]            in_ovr_res  [NUM_STAGES];
    logic [31:0]            eff_res     [NUM_STAGES];
    logic [EXCEPTION_W-1:0] eff_exc     [NUM_STAGES];
    logic [NUM_STAGES-1:0]  exc_flag, kill;
    logic                   exc_w;
    logic                   squash_q, squash_d;

    // Value a stage carries out: memory/mul results are sampled on leaving
    // their capture stage, load/store taking priority over mul.
    always_comb begin
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            is_ls[i]       = stage_q[i].ctrl[CTRL_LOAD] | stage_q[i].ctrl[CTRL_STORE];
            is_mul[i]      = stage_q[i].ctrl[CTRL_MUL];
            ovr_res_en[i]  = 1'b0;
            ovr_res_val[i] = mem_result_i;
            ovr_exc_en[i]  = 1'b0;
            if (i == LOAD_IDX && is_ls[i]) begin
                ovr_res_en[i] = 1'b1;
                ovr_exc_en[i] = mem_complete_i && (stage_q[i].exception == '0);
            end else if (i == MUL_IDX && is_mul[i]) begin
                ovr_res_en[i]  = 1'b1;
                ovr_res_val[i] = mul_result_i;
            end
            eff_res[i]  = ovr_res_en[i] ? ovr_res_val[i] : stage_q[i].result;
            eff_exc[i]  = ovr_exc_en[i] ? mem_exception_i : stage_q[i].exception;
            exc_flag[i] = stage_q[i].valid && (eff_exc[i] != '0);
        end
    end

    always_comb begin
        kill = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            for (int unsigned j = i + 1; j < NUM_STAGES; j++) begin
                if (exc_flag[j]) kill[i] = 1'b1;
            end
        end
    end

    assign exc_w    = |exc_flag;
    assign squash_o = exc_w | squash_q;
    assign squash_d = issue_stall_i ? squash_q : exc_w;
    assign stall_o  = stage_q[LOAD_IDX].valid & is_ls[LOAD_IDX] & ~mem_complete_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) squash_q <= 1'b0;
        else       squash_q <= squash_d;
    end

    always_comb begin
        stage_in[0]                      = '0;
        stage_in[0].valid                = issue_valid_i & issue_accept_i;
        stage_in[0].ctrl[CTRL_LOAD]      = issue_lsu_i & issue_rd_valid_i;
        stage_in[0].ctrl[CTRL_STORE]     = issue_lsu_i & ~issue_rd_valid_i;
        stage_in[0].ctrl[CTRL_MUL]       = issue_mul_i;
        stage_in[0].ctrl[CTRL_RD_VALID]  = issue_rd_valid_i;
        stage_in[0].pc                   = issue_pc_i;
        stage_in[0].opcode               = issue_opcode_i;
        stage_in[0].result               = alu_result_e1_i;
        stage_in[0].exception            = issue_exception_i;
        stage_clr[0]                     = squash_o | squash_i;
        in_ovr_res_en[0]                 = 1'b0;
        in_ovr_res[0]                    = '0;
        in_ovr_exc_en[0]                 = 1'b0;
        for (int unsigned i = 1; i < NUM_STAGES; i++) begin
            stage_in[i]      = stage_q[i-1];
            stage_clr[i]     = kill[i-1] | squash_i;
            in_ovr_res_en[i] = ovr_res_en[i-1];
            in_ovr_res[i]    = ovr_res_val[i-1];
            in_ovr_exc_en[i] = ovr_exc_en[i-1];
        end
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        biriscv_pipe_stage u_stage (
            .clk_i           (clk_i),
            .rst_i           (rst_i),
            .hold_i          (issue_stall_i),
            .clear_i         (stage_clr[g]),
            .stage_i         (stage_in[g]),
            .ovr_result_i    (in_ovr_res_en[g]),
            .ovr_result_val_i(in_ovr_res[g]),
            .ovr_exc_i       (in_ovr_exc_en[g]),
            .ovr_exc_val_i   (mem_exception_i),
            .stage_o         (stage_q[g])
        );
    end

    always_comb begin
        stage_valid_o  = '0;
        stage_rd_o     = '0;
        stage_result_o = '0;
        fwd_ready      = '0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            stage_valid_o[i]           = stage_q[i].valid;
            stage_result_o[i*32 +: 32] = eff_res[i];
            fwd_ready[i]               = 1'b1;
            if (stage_q[i].ctrl[CTRL_LOAD] &&
                (i < LOAD_IDX || (i == LOAD_IDX && !mem_complete_i))) fwd_ready[i] = 1'b0;
            if (is_mul[i] && i < MUL_IDX) fwd_ready[i] = 1'b0;
            if (stage_q[i].valid && stage_q[i].ctrl[CTRL_RD_VALID] && !stall_o && fwd_ready[i])
                stage_rd_o[i*5 +: 5] = stage_q[i].opcode[11:7];
        end
    end

    logic                   valid_wb_q, valid_wb_d;
    logic                   rd_valid_wb_q, rd_valid_wb_d;
    logic [4:0]             rd_q, rd_d;
    logic [31:0]            result_wb_q, result_wb_d;
    logic [31:0]            pc_wb_q, pc_wb_d;
    logic [EXCEPTION_W-1:0] exception_wb_q, exception_wb_d;
    logic                   unused_opcode_bits;

    always_comb begin
        valid_wb_d     = valid_wb_q;
        rd_valid_wb_d  = rd_valid_wb_q;
        rd_d           = rd_q;
        result_wb_d    = result_wb_q;
        pc_wb_d        = pc_wb_q;
        exception_wb_d = exception_wb_q;
        if (!issue_stall_i) begin
            valid_wb_d     = 1'b0;
            rd_valid_wb_d  = 1'b0;
            rd_d           = '0;
            result_wb_d    = '0;
            pc_wb_d        = '0;
            exception_wb_d = '0;
            if (stage_q[LAST_IDX].valid) begin
                valid_wb_d     = !is_mem_exception(eff_exc[LAST_IDX]);
                rd_valid_wb_d  = stage_q[LAST_IDX].ctrl[CTRL_RD_VALID] && (eff_exc[LAST_IDX] == '0);
                rd_d           = stage_q[LAST_IDX].opcode[11:7];
                result_wb_d    = eff_res[LAST_IDX];
                pc_wb_d        = stage_q[LAST_IDX].pc;
                exception_wb_d = eff_exc[LAST_IDX];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_wb_q     <= 1'b0;
            rd_valid_wb_q  <= 1'b0;
            rd_q           <= '0;
            result_wb_q    <= '0;
            pc_wb_q        <= '0;
            exception_wb_q <= '0;
        end else begin
            valid_wb_q     <= valid_wb_d;
            rd_valid_wb_q  <= rd_valid_wb_d;
            rd_q           <= rd_d;
            result_wb_q    <= result_wb_d;
            pc_wb_q        <= pc_wb_d;
            exception_wb_q <= exception_wb_d;
        end
    end

    assign valid_wb_o     = valid_wb_q & ~issue_stall_i;
    assign rd_wb_o        = (valid_wb_o && rd_valid_wb_q) ? rd_q : '0;
    assign result_wb_o    = result_wb_q;
    assign pc_wb_o        = pc_wb_q;
    assign exception_wb_o = exception_wb_q;

    assign unused_opcode_bits = ^{stage_q[LAST_IDX].opcode[31:12], stage_q[LAST_IDX].opcode[6:0]};

`ifdef BIRISCV_PIPE_PERF_EN
    logic [31:0] perf_retired_q, perf_retired_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_retired_d = perf_retired_q + {31'd0, valid_wb_o};
        perf_stall_d   = perf_stall_q + {31'd0, stall_o};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_retired_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_retired_q <= perf_retired_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_retired_o      = perf_retired_q;
    assign perf_stall_cycles_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_biriscv_pipe_ctrl_deep.sv
// Directed bench for biriscv_pipe_ctrl_deep (N=3, LOAD_STAGE=2, MUL_STAGE=3):
// per-cycle vector table plus hand-written corner-case sequences.
module tb_biriscv_pipe_ctrl_deep;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i, issue_accept_i, issue_stall_i, issue_lsu_i, issue_mul_i;
    logic        issue_rd_valid_i;
    logic [5:0]  issue_exception_i;
    logic [31:0] issue_pc_i, issue_opcode_i, alu_result_e1_i;
    logic        mem_complete_i;
    logic [31:0] mem_result_i;
    logic [5:0]  mem_exception_i;
    logic [31:0] mul_result_i;
    logic        squash_i;
    logic [2:0]  stage_valid_o;
    logic [14:0] stage_rd_o;
    logic [95:0] stage_result_o;
    logic        stall_o, squash_o, valid_wb_o;
    logic [4:0]  rd_wb_o;
    logic [31:0] result_wb_o, pc_wb_o;
    logic [5:0]  exception_wb_o;
`ifdef BIRISCV_PIPE_PERF_EN
    logic [31:0] perf_retired, perf_stall;
`endif
    logic        ext_stall;

    // Issue folds the memory stall into the global stall.
    assign issue_stall_i = ext_stall | stall_o;

    always #5 clk_i = ~clk_i;

    biriscv_pipe_ctrl_deep #(
        .NUM_STAGES(3),
        .LOAD_STAGE(2),
        .MUL_STAGE (3)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .issue_valid_i    (issue_valid_i),
        .issue_accept_i   (issue_accept_i),
        .issue_stall_i    (issue_stall_i),
        .issue_lsu_i      (issue_lsu_i),
        .issue_mul_i      (issue_mul_i),
        .issue_rd_valid_i (issue_rd_valid_i),
        .issue_exception_i(issue_exception_i),
        .issue_pc_i       (issue_pc_i),
        .issue_opcode_i   (issue_opcode_i),
        .alu_result_e1_i  (alu_result_e1_i),
        .mem_complete_i   (mem_complete_i),
        .mem_result_i     (mem_result_i),
        .mem_exception_i  (mem_exception_i),
        .mul_result_i     (mul_result_i),
        .squash_i         (squash_i),
        .stage_valid_o    (stage_valid_o),
        .stage_rd_o       (stage_rd_o),
        .stage_result_o   (stage_result_o),
        .stall_o          (stall_o),
        .squash_o         (squash_o),
        .valid_wb_o       (valid_wb_o),
        .rd_wb_o          (rd_wb_o),
        .result_wb_o      (result_wb_o),
        .pc_wb_o          (pc_wb_o),
        .exception_wb_o   (exception_wb_o)
`ifdef BIRISCV_PIPE_PERF_EN
        ,
        .perf_retired_o     (perf_retired),
        .perf_stall_cycles_o(perf_stall)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        iv, lsu, mul, rdv;
        logic [31:0] opc, alu;
        logic        mc;
        logic [31:0] mres;
        logic [2:0]  e_valid;
        logic [14:0] e_rd;
        logic        e_stall, e_squash, e_vwb;
        logic [4:0]  e_rdwb;
        logic [31:0] e_res;
    } vec_t;

    function automatic vec_t mk(input logic iv, lsu, mul, rdv, input logic [31:0] opc, alu,
                                input logic mc, input logic [31:0] mres, input logic [2:0] ev,
                                input logic [14:0] erd, input logic es, esq, evwb,
                                input logic [4:0] erdwb, input logic [31:0] eres);
        vec_t v;
        v.iv = iv; v.lsu = lsu; v.mul = mul; v.rdv = rdv; v.opc = opc; v.alu = alu;
        v.mc = mc; v.mres = mres; v.e_valid = ev; v.e_rd = erd; v.e_stall = es;
        v.e_squash = esq; v.e_vwb = evwb; v.e_rdwb = erdwb; v.e_res = eres;
        return v;
    endfunction

    task automatic drive(input logic iv, lsu, mul, rdv, input logic [5:0] exc,
                         input logic [31:0] opc, alu, pc);
        issue_valid_i     = iv;
        issue_accept_i    = iv;
        issue_lsu_i       = lsu;
        issue_mul_i       = mul;
        issue_rd_valid_i  = rdv;
        issue_exception_i = exc;
        issue_opcode_i    = opc;
        alu_result_e1_i   = alu;
        issue_pc_i        = pc;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 6'd0, 32'd0, 32'd0, 32'd0);
        mem_complete_i  = 1'b0;
        mem_result_i    = '0;
        mem_exception_i = '0;
        mul_result_i    = '0;
        squash_i        = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    vec_t vt [14];
    logic [31:0] slot;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ext_stall = 1'b0;
        rst_i     = 1'b1;
        idle();
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_stage_valid", stage_valid_o, 0);
        chk("rst_stage_rd", stage_rd_o, 0);
        chk("rst_stage_result", stage_result_o[63:0], 0);
        chk("rst_stall", stall_o, 0);
        chk("rst_squash", squash_o, 0);
        chk("rst_valid_wb", valid_wb_o, 0);
        chk("rst_rd_wb", rd_wb_o, 0);
        chk("rst_result_wb", result_wb_o, 0);
        chk("rst_pc_wb", pc_wb_o, 0);
        chk("rst_exc_wb", exception_wb_o, 0);
        tick();
        rst_i = 1'b0;
        tick();

        // ALU rd=5 flow, then load rd=7 with 3-cycle memory stall
        vt[0]  = mk(1,0,0,1, 32'h2B3, 32'h1234, 0, 0, 3'b000, 15'h0000, 0,0,0, 0, 0);
        vt[1]  = mk(0,0,0,0, 0, 0,              0, 0, 3'b001, 15'h0005, 0,0,0, 0, 0);
        vt[2]  = mk(0,0,0,0, 0, 0,              0, 0, 3'b010, 15'h00A0, 0,0,0, 0, 0);
        vt[3]  = mk(0,0,0,0, 0, 0,              0, 0, 3'b100, 15'h1400, 0,0,0, 0, 0);
        vt[4]  = mk(0,0,0,0, 0, 0,              0, 0, 3'b000, 15'h0000, 0,0,1, 5, 32'h1234);
        vt[5]  = mk(0,0,0,0, 0, 0,              0, 0, 3'b000, 15'h0000, 0,0,0, 0, 0);
        vt[6]  = mk(1,1,0,1, 32'h383, 32'h100,  0, 0, 3'b000, 15'h0000, 0,0,0, 0, 0);
        vt[7]  = mk(0,0,0,0, 0, 0,              0, 0, 3'b001, 15'h0000, 0,0,0, 0, 0);
        vt[8]  = mk(0,0,0,0, 0, 0,              0, 0, 3'b010, 15'h0000, 1,0,0, 0, 0);
        vt[9]  = mk(0,0,0,0, 0, 0,              0, 0, 3'b010, 15'h0000, 1,0,0, 0, 0);
        vt[10] = mk(0,0,0,0, 0, 0,              0, 0, 3'b010, 15'h0000, 1,0,0, 0, 0);
        vt[11] = mk(0,0,0,0, 0, 0, 1, 32'hCAFEF00D, 3'b010, 15'h00E0, 0,0,0, 0, 0);
        vt[12] = mk(0,0,0,0, 0, 0,              0, 0, 3'b100, 15'h1C00, 0,0,0, 0, 0);
        vt[13] = mk(0,0,0,0, 0, 0,              0, 0, 3'b000, 15'h0000, 0,0,1, 7, 32'hCAFEF00D);

        for (int i = 0; i < 14; i++) begin
            drive(vt[i].iv, vt[i].lsu, vt[i].mul, vt[i].rdv, 6'd0, vt[i].opc, vt[i].alu,
                  32'h1000 + 32'(i) * 4);
            mem_complete_i = vt[i].mc;
            mem_result_i   = vt[i].mres;
            @(negedge clk_i);
            chk($sformatf("v%0d_stage_valid", i), stage_valid_o, vt[i].e_valid);
            chk($sformatf("v%0d_stage_rd", i), stage_rd_o, vt[i].e_rd);
            chk($sformatf("v%0d_stall", i), stall_o, vt[i].e_stall);
            chk($sformatf("v%0d_squash", i), squash_o, vt[i].e_squash);
            chk($sformatf("v%0d_valid_wb", i), valid_wb_o, vt[i].e_vwb);
            chk($sformatf("v%0d_rd_wb", i), rd_wb_o, vt[i].e_rdwb);
            chk($sformatf("v%0d_result_wb", i), result_wb_o, vt[i].e_res);
            tick();
        end
        idle();

        // Load with misaligned-load exception at E2, younger ALU in E1
        drive(1, 1, 0, 1, 6'd0, 32'h383, 32'h201, 32'h3000);
        tick();
        drive(1, 0, 0, 1, 6'd0, 32'h1B3, 32'h77, 32'h3004);
        tick();
        idle();
        mem_complete_i  = 1'b1;
        mem_exception_i = 6'd4;
        @(negedge clk_i);
        chk("mexc_squash_e2", squash_o, 1);
        chk("mexc_stall_e2", stall_o, 0);
        chk("mexc_valid_e2", stage_valid_o, 3'b011);
        tick();
        idle();
        @(negedge clk_i);
        chk("mexc_valid_e3", stage_valid_o, 3'b100);
        chk("mexc_squash_e3", squash_o, 1);
        tick();
        @(negedge clk_i);
        chk("mexc_valid_wb", valid_wb_o, 0);
        chk("mexc_exc_wb", exception_wb_o, 4);
        chk("mexc_rd_wb", rd_wb_o, 0);
        chk("mexc_stages_empty", stage_valid_o, 0);
        tick();
        @(negedge clk_i);
        chk("mexc_squash_done", squash_o, 0);

        // Frontend exception 2 with a mul right behind
        drive(1, 0, 0, 1, 6'd2, 32'h493, 32'h0, 32'h2000);
        tick();
        drive(1, 0, 1, 1, 6'd0, 32'h533, 32'h0, 32'h2004);
        @(negedge clk_i);
        chk("fexc_squash", squash_o, 1);
        tick();
        idle();
        @(negedge clk_i);
        chk("fexc_mul_dropped", stage_valid_o, 3'b010);
        tick();
        tick();
        @(negedge clk_i);
        chk("fexc_valid_wb", valid_wb_o, 1);
        chk("fexc_exc_wb", exception_wb_o, 2);
        chk("fexc_rd_wb", rd_wb_o, 0);
        chk("fexc_pc_wb", pc_wb_o, 32'h2000);
        tick();
        @(negedge clk_i);
        chk("fexc_no_mul_commit", valid_wb_o, 0);

        // Mul rd=11 with dependent ALU rd=12 behind it
        drive(1, 0, 1, 1, 6'd0, 32'h5B3, 32'h0, 32'h4000);
        tick();
        drive(1, 0, 0, 1, 6'd0, 32'h633, 32'h55, 32'h4004);
        @(negedge clk_i);
        chk("mul_e1_rd", stage_rd_o, 0);
        tick();
        idle();
        @(negedge clk_i);
        chk("mul_e2_rd", stage_rd_o, 15'h000C);
        tick();
        mul_result_i = 32'hDEAD0001;
        @(negedge clk_i);
        chk("mul_e3_valid", stage_valid_o, 3'b110);
        chk("mul_e3_rd", stage_rd_o, 15'h2D80);
        slot = stage_result_o[95:64];
        chk("mul_e3_result", slot, 32'hDEAD0001);
        tick();
        mul_result_i = '0;
        @(negedge clk_i);
        chk("mul_wb_valid", valid_wb_o, 1);
        chk("mul_wb_rd", rd_wb_o, 11);
        chk("mul_wb_result", result_wb_o, 32'hDEAD0001);
        chk("mul_alu_e3_rd", stage_rd_o, 15'h3000);
        tick();
        @(negedge clk_i);
        chk("mul_alu_wb_rd", rd_wb_o, 12);
        chk("mul_alu_wb_result", result_wb_o, 32'h55);

        // External squash clears E1..EN but lets EN retire into WB
        drive(1, 0, 0, 1, 6'd0, 32'h233, 32'h44, 32'h5000);
        tick();
        idle();
        tick();
        drive(1, 0, 0, 1, 6'd0, 32'h333, 32'h66, 32'h5008);
        tick();
        idle();
        squash_i = 1'b1;
        @(negedge clk_i);
        chk("sqi_valid_before", stage_valid_o, 3'b101);
        tick();
        squash_i = 1'b0;
        @(negedge clk_i);
        chk("sqi_valid_after", stage_valid_o, 0);
        chk("sqi_wb_valid", valid_wb_o, 1);
        chk("sqi_wb_rd", rd_wb_o, 4);
        tick();

        // Reset asserted mid-stall with three valid stages
        drive(1, 0, 0, 1, 6'd0, 32'h0B3, 32'h1, 32'h6000);
        tick();
        drive(1, 1, 0, 1, 6'd0, 32'h103, 32'h2, 32'h6004);
        tick();
        drive(1, 0, 0, 1, 6'd0, 32'h1B3, 32'h3, 32'h6008);
        tick();
        idle();
        @(negedge clk_i);
        chk("rstm_valid", stage_valid_o, 3'b111);
        chk("rstm_stall", stall_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("rstm_valid_cleared", stage_valid_o, 0);
        chk("rstm_stall_cleared", stall_o, 0);
        chk("rstm_squash_cleared", squash_o, 0);
        chk("rstm_valid_wb", valid_wb_o, 0);
        chk("rstm_rd_wb", rd_wb_o, 0);
        chk("rstm_result_wb", result_wb_o, 0);
        tick();
        rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            chk($sformatf("rstm_no_commit_%0d", c), valid_wb_o, 0);
            chk($sformatf("rstm_empty_%0d", c), stage_valid_o, 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
